// File: rtl/if_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: bus widths,
// chip-enable levels and the fetch FSM state encoding.
package if_ctrl_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  // Sequential fetch stride in bytes.
  localparam logic [XLEN-1:0] InstBytes = 32'd4;

  typedef enum logic [1:0] {
    StateOff  = 2'd0,
    StateReq  = 2'd1,
    StateWait = 2'd2,
    StateHold = 2'd3
  } FetchState;

  // True in the states that drive an instruction memory read.
  function automatic logic isFetching(input FetchState s);
    return (s == StateReq) || (s == StateWait);
  endfunction

endpackage

// File: rtl/if_ctrl.sv
// Instruction-fetch controller: issues one instruction memory read at a time,
// delivers the result to decode, buffers it while decode is stalled and
// follows branch (and optionally exception) redirects.
// Optional feature macro: IF_CTRL_EXC_EN adds exc_flag/exc_addr, an exception
// redirect that outranks branches.
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_flag,
  input  logic [XLEN-1:0] branch_addr,
`ifdef IF_CTRL_EXC_EN
  input  logic            exc_flag,
  input  logic [XLEN-1:0] exc_addr,
`endif
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_inst,
  output logic            ce,
  output logic [XLEN-1:0] pc,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  FetchState       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ce_q, ce_d;
  logic            req_q, req_d;
  logic            instValid_q, instValid_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] instPc_q, instPc_d;
  logic            pendValid_q, pendValid_d;
  logic [XLEN-1:0] pendAddr_q, pendAddr_d;

  logic            redirValid;
  logic [XLEN-1:0] redirTarget;

  // Merge this cycle's redirect sources, exception outranking branch.
  always_comb begin
    redirValid  = branch_flag;
    redirTarget = branch_addr;
`ifdef IF_CTRL_EXC_EN
    if (exc_flag) begin
      redirValid  = 1'b1;
      redirTarget = exc_addr;
    end
`endif
  end

  // Next-state logic: fetch sequencing, decode hand-off and redirect handling.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instValid_d = 1'b0;
    inst_d      = inst_q;
    instPc_d    = instPc_q;
    pendValid_d = pendValid_q;
    pendAddr_d  = pendAddr_q;

    case (state_q)
      StateOff: begin
        state_d = StateReq;
      end

      StateReq, StateWait: begin
        if (imem_ack) begin
          if (redirValid) begin
            pc_d        = redirTarget;
            pendValid_d = 1'b0;
            state_d     = StateReq;
          end else if (pendValid_q) begin
            pc_d        = pendAddr_q;
            pendValid_d = 1'b0;
            state_d     = StateReq;
          end else begin
            inst_d      = imem_inst;
            instPc_d    = pc_q;
            instValid_d = 1'b1;
            if (stall) begin
              state_d = StateHold;
            end else begin
              pc_d    = pc_q + InstBytes;
              state_d = StateReq;
            end
          end
        end else begin
          if (redirValid) begin
            pendValid_d = 1'b1;
            pendAddr_d  = redirTarget;
          end
          state_d = StateWait;
        end
      end

      StateHold: begin
        if (redirValid) begin
          pc_d    = redirTarget;
          state_d = StateReq;
        end else if (stall) begin
          instValid_d = 1'b1;
        end else begin
          pc_d    = pc_q + InstBytes;
          state_d = StateReq;
        end
      end

      default: begin
        state_d = StateOff;
      end
    endcase

    ce_d  = (state_d == StateOff) ? ChipDisable : ChipEnable;
    req_d = isFetching(state_d);
  end

  // State and registered outputs, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StateOff;
      pc_q        <= RESET_PC;
      ce_q        <= ChipDisable;
      req_q       <= 1'b0;
      instValid_q <= 1'b0;
      inst_q      <= '0;
      instPc_q    <= '0;
      pendValid_q <= 1'b0;
      pendAddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ce_q        <= ce_d;
      req_q       <= req_d;
      instValid_q <= instValid_d;
      inst_q      <= inst_d;
      instPc_q    <= instPc_d;
      pendValid_q <= pendValid_d;
      pendAddr_q  <= pendAddr_d;
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = req_q;
  assign ce         = ce_q;
  assign inst_valid = instValid_q;
  assign inst       = inst_q;
  assign inst_pc    = instPc_q;

endmodule
